// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter / branch unit.
package pc_pkg;

    localparam int PC_W      = 10;
    localparam int LUT_DEPTH = 8;
    localparam int RAS_DEPTH = 4;
    localparam int LUT_IDX_W = $clog2(LUT_DEPTH);
    localparam int RAS_PTR_W = $clog2(RAS_DEPTH + 1);

    typedef logic [PC_W-1:0] pc_t;

    // Bit positions inside the sticky error vector
    localparam int ERR_OVF = 0;
    localparam int ERR_UNF = 1;

endpackage

// File: rtl/pc_branch_unit_ras.sv
// Return-address stack: small LIFO, pointer counts occupied entries (0..DEPTH).
module pc_ras
    import pc_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH,
    parameter int W     = PC_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] top
);

    localparam int PTR_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     r_mem [2**IDX_W];
    logic [PTR_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_top_idx;
    logic [IDX_W-1:0] w_wr_idx;

    assign full      = (r_ptr == PTR_W'(DEPTH));
    assign empty     = (r_ptr == '0);
    assign w_top_idx = IDX_W'(r_ptr - PTR_W'(1));
    assign w_wr_idx  = IDX_W'(r_ptr);
    assign top       = empty ? '0 : r_mem[w_top_idx];

    // Pointer and storage update; pop wins if both strobes arrive together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
            for (int i = 0; i < 2**IDX_W; i++) r_mem[i] <= '0;
        end else if (pop && !empty) begin
            r_ptr <= r_ptr - PTR_W'(1);
        end else if (push && !full) begin
            r_mem[w_wr_idx] <= din;
            r_ptr           <= r_ptr + PTR_W'(1);
        end
    end

endmodule

// File: rtl/pc_branch_unit.sv
// Fetch program counter with branch-target LUT, call/return stack, stall and sticky halt.
module pc_branch_unit #(
    parameter int          PC_W       = 10,
    parameter int          LUT_DEPTH  = 8,
    parameter int          RAS_DEPTH  = 4,
    parameter int unsigned START_ADDR = 0,
    parameter int unsigned LAST_ADDR  = 2**PC_W - 1
) (
    input  logic                         CLK,
    input  logic                         init_n,
    input  logic                         stall,
    input  logic                         br_en,
    input  logic                         br_uncond,
    input  logic                         br_abs,
    input  logic [$clog2(LUT_DEPTH)-1:0] br_idx,
    input  logic                         EQUAL,
    input  logic                         call,
    input  logic                         ret,
    input  logic                         halt_req,
    input  logic                         lut_we,
    input  logic [$clog2(LUT_DEPTH)-1:0] lut_waddr,
    input  logic [PC_W-1:0]              lut_wdata,
    output logic [PC_W-1:0]              PC,
    output logic                         halt,
    output logic [1:0]                   err
);

    logic [1:0]      r_rst_sync;
    logic            w_rst_n;
    logic [PC_W-1:0] r_pc;
    logic            r_halt;
    logic [1:0]      r_err;
    logic [PC_W-1:0] r_lut [LUT_DEPTH];

    logic [PC_W-1:0] w_lut_rd;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_pc_rel;
    logic            w_taken;
    logic            w_active;
    logic            w_push;
    logic            w_pop;
    logic            w_ras_full;
    logic            w_ras_empty;
    logic [PC_W-1:0] w_ras_top;

    // Reset asserts immediately, releases two CLK edges after init_n rises
    always_ff @(posedge CLK or negedge init_n) begin
        if (!init_n) r_rst_sync <= 2'b00;
        else         r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_lut_rd = r_lut[br_idx];
    assign w_pc_inc = r_pc + PC_W'(1);
    // LUT entry is already PC_W wide, so a PC_W-bit add is the sign-extended add mod 2**PC_W
    assign w_pc_rel = r_pc + w_lut_rd;
    assign w_taken  = br_en && (br_uncond || EQUAL);
    assign w_active = !r_halt && !halt_req && !stall;
    assign w_pop    = w_active && ret && !w_ras_empty;
    assign w_push   = w_active && !ret && call && !w_ras_full;

    pc_ras #(
        .DEPTH (RAS_DEPTH),
        .W     (PC_W)
    ) u_ras (
        .clk   (CLK),
        .rst_n (w_rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_pc_inc),
        .full  (w_ras_full),
        .empty (w_ras_empty),
        .top   (w_ras_top)
    );

    // Branch-target table: written regardless of stall/halt, new value visible next cycle
    always_ff @(posedge CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            for (int i = 0; i < LUT_DEPTH; i++) r_lut[i] <= '0;
        end else if (lut_we) begin
            r_lut[lut_waddr] <= lut_wdata;
        end
    end

    // Next-PC selection in priority order, with sticky halt and error flags
    always_ff @(posedge CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_pc   <= PC_W'(START_ADDR);
            r_halt <= 1'b0;
            r_err  <= 2'b00;
        end else if (r_halt) begin
            r_pc <= r_pc;
        end else if (halt_req) begin
            r_halt <= 1'b1;
        end else if (stall) begin
            r_pc <= r_pc;
        end else if (ret) begin
            if (w_ras_empty) begin
                r_err[pc_pkg::ERR_UNF] <= 1'b1;
                r_halt                 <= 1'b1;
            end else begin
                r_pc <= w_ras_top;
            end
        end else if (call) begin
            if (w_ras_full) begin
                r_err[pc_pkg::ERR_OVF] <= 1'b1;
                r_halt                 <= 1'b1;
            end else begin
                r_pc <= w_lut_rd;
            end
        end else if (w_taken) begin
            r_pc <= br_abs ? w_lut_rd : w_pc_rel;
        end else if (r_pc == PC_W'(LAST_ADDR)) begin
            r_halt <= 1'b1;
        end else begin
            r_pc <= w_pc_inc;
        end
    end

    assign PC   = r_pc;
    assign halt = r_halt;
    assign err  = r_err;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Scoreboard bench: driver runs a behavioural model and queues expected state, monitor compares.
module tb_pc_branch_unit;
    import pc_pkg::*;

    localparam int ADDR_SPACE = 2**PC_W;
    localparam int LAST       = ADDR_SPACE - 1;

    logic                 CLK;
    logic                 init_n;
    logic                 stall, br_en, br_uncond, br_abs, EQUAL;
    logic                 call, ret, halt_req, lut_we;
    logic [LUT_IDX_W-1:0] br_idx, lut_waddr;
    logic [PC_W-1:0]      lut_wdata;
    logic [PC_W-1:0]      PC;
    logic                 halt;
    logic [1:0]           err;

    pc_branch_unit dut (
        .CLK       (CLK),
        .init_n    (init_n),
        .stall     (stall),
        .br_en     (br_en),
        .br_uncond (br_uncond),
        .br_abs    (br_abs),
        .br_idx    (br_idx),
        .EQUAL     (EQUAL),
        .call      (call),
        .ret       (ret),
        .halt_req  (halt_req),
        .lut_we    (lut_we),
        .lut_waddr (lut_waddr),
        .lut_wdata (lut_wdata),
        .PC        (PC),
        .halt      (halt),
        .err       (err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        int       pc;
        bit       halt;
        bit [1:0] err;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_vec  = 0;
    int   n_miss = 0;

    // Reference model state
    int       m_pc;
    bit       m_halt;
    bit [1:0] m_err;
    int       m_lut [LUT_DEPTH];
    int       m_ras [$];

    task automatic model_reset();
        m_pc   = 0;
        m_halt = 0;
        m_err  = 2'b00;
        for (int i = 0; i < LUT_DEPTH; i++) m_lut[i] = 0;
        m_ras.delete();
    endtask

    // One clock of behaviour from the current inputs; expected post-edge state is queued
    task automatic issue();
        int   tgt;
        int   off;
        exp_t e;
        tgt = m_lut[br_idx];
        if (!m_halt) begin
            if (halt_req) m_halt = 1;
            else if (stall) begin end
            else if (ret) begin
                if (m_ras.size() == 0) begin m_err[1] = 1'b1; m_halt = 1; end
                else m_pc = m_ras.pop_back();
            end else if (call) begin
                if (m_ras.size() == RAS_DEPTH) begin m_err[0] = 1'b1; m_halt = 1; end
                else begin
                    m_ras.push_back((m_pc + 1) % ADDR_SPACE);
                    m_pc = tgt;
                end
            end else if (br_en && (br_uncond || EQUAL)) begin
                if (br_abs) m_pc = tgt;
                else begin
                    off  = (tgt >= ADDR_SPACE / 2) ? tgt - ADDR_SPACE : tgt;
                    m_pc = (m_pc + off + ADDR_SPACE) % ADDR_SPACE;
                end
            end else if (m_pc == LAST) m_halt = 1;
            else m_pc = m_pc + 1;
        end
        if (lut_we) m_lut[lut_waddr] = int'(lut_wdata);
        e.pc = m_pc; e.halt = m_halt; e.err = m_err;
        sb_q.push_back(e);
        @(negedge CLK);
    endtask

    // Monitor: every cycle the DUT presents a new PC; compare against the oldest expectation
    always @(posedge CLK) begin
        #1;
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            n_vec++;
            if (PC !== pc_t'(mon_e.pc) || halt !== mon_e.halt || err !== mon_e.err) begin
                n_miss++;
                $display("FAIL sb_check t=%0t pc got %h want %h halt got %b want %b err got %b want %b",
                         $time, PC, pc_t'(mon_e.pc), halt, mon_e.halt, err, mon_e.err);
            end
        end
    end

    // Illegal same-cycle strobes must never be generated by this bench
    always @(posedge CLK) begin
        assert (int'(call) + int'(ret) + int'(br_en) <= 1)
            else $error("FAIL illegal_strobes call=%b ret=%b br_en=%b", call, ret, br_en);
    end

    task automatic chk(input string name, input int exp_pc, input bit exp_h, input bit [1:0] exp_e);
        n_vec++;
        if (PC !== pc_t'(exp_pc) || halt !== exp_h || err !== exp_e) begin
            n_miss++;
            $display("FAIL %s pc got %h want %h halt got %b want %b err got %b want %b",
                     name, PC, pc_t'(exp_pc), halt, exp_h, err, exp_e);
        end
    endtask

    task automatic clr();
        stall = 0; br_en = 0; br_uncond = 0; br_abs = 0; EQUAL = 0;
        call = 0; ret = 0; halt_req = 0; lut_we = 0;
        br_idx = '0; lut_waddr = '0; lut_wdata = '0;
    endtask

    task automatic do_reset();
        clr();
        init_n = 1'b0;
        model_reset();
        @(negedge CLK);
        init_n = 1'b1;
        repeat (2) @(negedge CLK);
    endtask

    task automatic lut_wr(input int idx, input int val);
        clr(); lut_we = 1; lut_waddr = LUT_IDX_W'(idx); lut_wdata = PC_W'(val);
        issue();
    endtask

    task automatic set_pc(input int v);
        lut_wr(7, v);
        clr(); br_en = 1; br_uncond = 1; br_abs = 1; br_idx = 3'd7;
        issue();
    endtask

    task automatic rel_br(input int idx, input bit unc, input bit eq);
        clr(); br_en = 1; br_uncond = unc; EQUAL = eq; br_abs = 0; br_idx = LUT_IDX_W'(idx);
        issue();
    endtask

    task automatic do_call(input int idx);
        clr(); call = 1; br_idx = LUT_IDX_W'(idx);
        issue();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin clr(); issue(); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int halt_cycles;
        int sel;
        clr();
        init_n = 1'b0;
        model_reset();
        #12;
        chk("reset_state", 0, 0, 2'b00);
        @(negedge CLK);
        init_n = 1'b1;
        repeat (2) @(negedge CLK);

        // Sequential fetch, then asynchronous reset without a clock edge
        idle(5);
        chk("seq_pc5", 5, 0, 2'b00);
        @(posedge CLK);
        #2 init_n = 1'b0;
        #1 chk("async_reset", 0, 0, 2'b00);
        model_reset();
        @(negedge CLK);
        init_n = 1'b1;
        repeat (2) @(negedge CLK);

        // Relative branches: taken, not taken, unconditional, wrap
        lut_wr(2, 'h3FD);
        set_pc(10); rel_br(2, 0, 1); chk("rel_taken", 7, 0, 2'b00);
        set_pc(10); rel_br(2, 0, 0); chk("rel_not_taken", 11, 0, 2'b00);
        set_pc(10); rel_br(2, 1, 0); chk("rel_uncond", 7, 0, 2'b00);
        set_pc(1);  rel_br(2, 1, 0); chk("rel_wrap", 'h3FE, 0, 2'b00);

        // Fall through LAST_ADDR
        set_pc(LAST);
        idle(1);
        chk("last_halt", LAST, 1, 2'b00);
        idle(10);
        chk("last_hold", LAST, 1, 2'b00);
        do_reset();

        // Call / return and overflow
        lut_wr(1, 'h100);
        set_pc(20);
        do_call(1); chk("call", 'h100, 0, 2'b00);
        idle(2);
        clr(); ret = 1; issue(); chk("ret", 21, 0, 2'b00);
        for (int i = 0; i < 4; i++) do_call(1);
        chk("call_x4", 'h100, 0, 2'b00);
        do_call(1); chk("ras_overflow", 'h100, 1, 2'b01);
        do_reset();

        // Return with empty stack
        idle(3);
        clr(); ret = 1; issue(); chk("ras_underflow", 3, 1, 2'b10);
        do_reset();

        // Same-cycle LUT write/read returns old value; stall holds
        lut_wr(3, 'h020);
        clr(); lut_we = 1; lut_waddr = 3'd3; lut_wdata = 'h050;
        br_en = 1; br_uncond = 1; br_abs = 1; br_idx = 3'd3;
        issue(); chk("lut_old_value", 'h020, 0, 2'b00);
        clr(); br_en = 1; br_uncond = 1; br_abs = 1; br_idx = 3'd3;
        issue(); chk("lut_new_value", 'h050, 0, 2'b00);
        for (int i = 0; i < 3; i++) begin clr(); stall = 1; issue(); end
        chk("stall_hold", 'h050, 0, 2'b00);
        clr(); halt_req = 1; issue(); chk("halt_req", 'h050, 1, 2'b00);
        do_reset();

        // Randomised traffic
        halt_cycles = 0;
        for (int k = 0; k < 800; k++) begin
            clr();
            stall     = ($urandom_range(0, 99) < 8);
            halt_req  = ($urandom_range(0, 199) == 0);
            sel       = $urandom_range(0, 9);
            call      = (sel == 0);
            ret       = (sel == 1);
            br_en     = (sel >= 2 && sel <= 5);
            br_uncond = 1'($urandom_range(0, 1));
            br_abs    = 1'($urandom_range(0, 1));
            EQUAL     = 1'($urandom_range(0, 1));
            br_idx    = LUT_IDX_W'($urandom_range(0, LUT_DEPTH - 1));
            lut_we    = ($urandom_range(0, 3) == 0);
            lut_waddr = LUT_IDX_W'($urandom_range(0, LUT_DEPTH - 1));
            lut_wdata = PC_W'($urandom_range(0, ADDR_SPACE - 1));
            issue();
            if (m_halt) begin
                halt_cycles++;
                if (halt_cycles > 3) begin
                    do_reset();
                    halt_cycles = 0;
                end
            end
        end

        clr();
        repeat (2) @(negedge CLK);
        n_vec++;
        if (sb_q.size() != 0) begin
            n_miss++;
            $display("FAIL sb_drain left %0d want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/pc_branch_unit.md
Name: pc_branch_unit

Overview:
- Parametrised successor to the fetch program counter.
- Generates the instruction-memory address each cycle. Supports:
  - default increment;
  - conditional and unconditional branches, relative or absolute, with targets from a software-loadable branch lookup table (LUT);
  - call/return through a small return-address stack (RAS);
  - stall;
  - a sticky halt.
- Sits between the decoder/ALU flags and instruction memory. Fed decoded control strobes, not raw instruction bits.

Parameters:
- PC_W, 10, program counter width in bits; the address space is 2**PC_W.
- LUT_DEPTH, 8, number of branch-target LUT entries; must be a power of 2.
- RAS_DEPTH, 4, number of return-address stack entries; must be ≥1.
- START_ADDR, 0, PC value after reset.
- LAST_ADDR, 2**PC_W-1, address at which the unit halts when execution falls through.

Ports:
- CLK  in  1  clock; rising edge active.
- init_n  in  1  asynchronous, active-low reset.
- stall  in  1  hold PC this cycle.
- br_en  in  1  decoded branch instruction.
- br_uncond  in  1  branch ignores EQUAL.
- br_abs  in  1  1 = LUT entry is an absolute target; 0 = signed relative offset.
- br_idx  in  $clog2(LUT_DEPTH)  LUT index.
- EQUAL  in  1  ALU compare flag.
- call  in  1  push PC+1 and jump to absolute LUT[br_idx].
- ret  in  1  pop the RAS into PC.
- halt_req  in  1  software halt.
- lut_we  in  1  LUT write enable.
- lut_waddr  in  $clog2(LUT_DEPTH)  LUT write index.
- lut_wdata  in  PC_W  LUT write data.
- PC  out  PC_W  current fetch address.
- halt  out  1  sticky halt.
- err  out  2  sticky error: bit0 = RAS overflow, bit1 = RAS underflow.

Behaviour:
- Reset (init_n=0, asynchronous):
  - PC=START_ADDR, halt=0, err=0.
  - RAS pointer=0; all LUT and RAS entries = 0.
  - Release is synchronous to CLK through a 2-flop synchroniser on deassertion only.
- Reset mid-operation aborts everything, including pending LUT writes.
- All updates occur on the rising edge of CLK. PC changes one cycle after the strobe; there is no other latency.
- Next-PC priority, highest first:
  1. halt already set: PC holds; only reset clears halt.
  2. halt_req: halt<=1; PC holds.
  3. stall: PC, RAS and halt hold. LUT writes still occur.
  4. ret:
     - RAS empty: err[1]<=1, halt<=1, PC holds.
     - Otherwise: PC<=top of RAS; pointer decrements.
  5. call:
     - RAS full: err[0]<=1, halt<=1, PC holds.
     - Otherwise: push PC+1 (mod 2**PC_W) and set PC<=LUT[br_idx].
  6. Taken branch, where taken = br_en && (br_uncond || EQUAL):
     - br_abs=1: PC<=LUT[br_idx].
     - br_abs=0: PC<=PC + sign-extended LUT[br_idx], modulo 2**PC_W. Wrap-around in either direction is legal and silent.
  7. Not taken with PC==LAST_ADDR: halt<=1; PC holds.
  8. Otherwise: PC<=PC+1.
- More than one of call, ret and br_en set in the same cycle is illegal. If it occurs, the priority above resolves it; the bench asserts the condition never happens.
- LUT:
  - Synchronous write, combinational read.
  - A same-cycle write and read of one entry returns the old value; the new value is visible next cycle.
  - Writes are accepted while halted.
- A branch or call to LAST_ADDR lands there; the unit halts on the following non-redirect cycle.
- err bits and halt are sticky until reset.

Decomposition:
- Package pc_pkg:
  - typedef pc_t (logic [PC_W-1:0]);
  - localparam LUT_IDX_W, RAS_PTR_W;
  - err bit-position constants ERR_OVF=0, ERR_UNF=1.
- Sub-module pc_ras:
  - parametrised LIFO with push, pop, full, empty and top;
  - pointer range 0..RAS_DEPTH.
- The LUT stays inline as a register array.

Test Plan:
- Reset, then 5 idle cycles → PC sequence 0,1,2,3,4,5; halt=0. Assert init_n at PC=5 → PC=0 immediately, without waiting for a clock edge.
- Write LUT[2]=0x3FD (−3), PC=10, br_en=1, br_abs=0, br_idx=2, EQUAL=1 → PC=7. Repeat with EQUAL=0 → PC=11. Repeat with br_uncond=1, EQUAL=0 → PC=7.
- PC=1, relative offset −3 → PC=0x3FE (wrap). PC=0x3FF (LAST_ADDR) with no redirect → halt=1 and PC stays 0x3FF for 10 cycles.
- Load LUT[1]=0x100. At PC=20 assert call, idx 1 → PC=0x100. Later assert ret → PC=21. Four nested calls succeed; the fifth sets err=2'b01 and halt=1.
- ret with RAS empty → err=2'b10, halt=1, PC unchanged.
- In the same cycle, write LUT[3]=0x050 and take an absolute branch via idx 3 (old value 0x020) → PC=0x020; the next branch via idx 3 → PC=0x050. stall held 3 cycles → PC constant.
